// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core: forward-select encodings,
// default write-back latency and producer latencies.
package mips_pkg;

    localparam int WB_LAT_DEF = 3;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: the write-back and bypass-valid countdowns of a
// single architectural register, with load, decrement and kill-restore.
module sb_entry
    import mips_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int LW     = $clog2(WB_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [LW-1:0] load_lat_i,
    input  logic          restore_i,
    input  logic [LW-1:0] restore_wb_i,
    input  logic [LW-1:0] restore_av_i,
    output logic [LW-1:0] wb_o,
    output logic [LW-1:0] av_o
);

    logic [LW-1:0] wb_q, wb_d;
    logic [LW-1:0] av_q, av_d;

    function automatic logic [LW-1:0] dec_sat(input logic [LW-1:0] v);
        return (v == '0) ? '0 : v - LW'(1);
    endfunction

    // Effective view with a killed write already undone. Kept apart from the
    // next-state logic: load_i depends on these outputs through stall.
    assign wb_o = restore_i ? dec_sat(restore_wb_i) : wb_q;
    assign av_o = restore_i ? dec_sat(restore_av_i) : av_q;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        wb_d = dec_sat(wb_o);
        av_d = dec_sat(av_o);
        if (load_i) begin
            wb_d = LW'(WB_LAT);
            av_d = load_lat_i;
        end
    end

    // NOTE: non-blocking assignments for all flop state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
            av_q <= '0;
        end else begin
            wb_q <= wb_d;
            av_q <= av_d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard beside ID: per-operand stall / forward / RF decision
// from per-register countdowns, with a one-cycle shadow to undo a killed issue.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int LW     = $clog2(WB_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_rd,
    input  logic [LW-1:0] id_lat,
    input  logic          ex_kill,
    output logic          stall,
    output logic          issue,
    output logic [LW-1:0] fwd_a,
    output logic [LW-1:0] fwd_b
);

    localparam logic [LW-1:0] CNT_ONE = LW'(1);

    logic [LW-1:0] wb_eff [NREG];
    logic [LW-1:0] av_eff [NREG];

    logic          wr_issue;
    logic          kill_act;
    logic          haz_a, haz_b;
    logic [AW-1:0] last_rd_q, last_rd_d;
    logic          last_wr_q, last_wr_d;
    logic [LW-1:0] shadow_wb_q, shadow_wb_d;
    logic [LW-1:0] shadow_av_q, shadow_av_d;

    // Returns {hazard, fwd}. Bypass-valid count 1 is usable at EX next cycle.
    function automatic logic [LW:0] src_check(input logic          use_x,
                                              input logic [AW-1:0] x,
                                              input logic [LW-1:0] wb,
                                              input logic [LW-1:0] av);
        logic          haz;
        logic [LW-1:0] fwd;
        haz = 1'b0;
        fwd = LW'(FWD_RF);
        if (use_x && (x != '0)) begin
            if (av > CNT_ONE)      haz = 1'b1;
            else if (wb > CNT_ONE) fwd = LW'(WB_LAT) - wb + CNT_ONE;
        end
        return {haz, fwd};
    endfunction

    assign kill_act = ex_kill && last_wr_q;
    assign issue    = id_valid && !stall;
    assign wr_issue = issue && id_wr_en && (id_rd != '0);

    assign wb_eff[0] = '0;
    assign av_eff[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .WB_LAT (WB_LAT),
            .LW     (LW)
        ) u_entry (
            .clk          (clk),
            .rst          (rst),
            .load_i       (wr_issue && (id_rd == AW'(r))),
            .load_lat_i   (id_lat),
            .restore_i    (kill_act && (last_rd_q == AW'(r))),
            .restore_wb_i (shadow_wb_q),
            .restore_av_i (shadow_av_q),
            .wb_o         (wb_eff[r]),
            .av_o         (av_eff[r])
        );
    end

    always_comb begin
        {haz_a, fwd_a} = src_check(id_use_rs, id_rs, wb_eff[id_rs], av_eff[id_rs]);
        {haz_b, fwd_b} = src_check(id_use_rt, id_rt, wb_eff[id_rt], av_eff[id_rt]);
        stall = id_valid && (haz_a || haz_b);
    end

    // Shadow captures the destination's state after any same-cycle restore
    // but before this issue's load, so a later kill exposes the older write.
    always_comb begin
        last_rd_d   = id_rd;
        last_wr_d   = wr_issue;
        shadow_wb_d = wb_eff[id_rd];
        shadow_av_d = av_eff[id_rd];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_rd_q   <= '0;
            last_wr_q   <= 1'b0;
            shadow_wb_q <= '0;
            shadow_av_q <= '0;
        end else begin
            last_rd_q   <= last_rd_d;
            last_wr_q   <= last_wr_d;
            shadow_wb_q <= shadow_wb_d;
            shadow_av_q <= shadow_av_d;
        end
    end

endmodule
